// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK sample.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  output logic [2:0] fsm_state
);
  // Request handshake: tx_data is taken on a clk edge where tx_valid and tx_ready are both 1;
  // tx_ready is high only in IDLE, so requests during a transfer are neither taken nor queued.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

  state_t        state, state_n;
  logic [2:0]    sync_clk, sync_dat;
  logic          fall;
  logic [7:0]    data_r;
  logic          par_r;
  logic [3:0]    edge_cnt;
  logic [IW-1:0] inh_cnt;
  logic          dat_oe_r;
  logic          ack_r;
  logic          unused_sync;

  assign fall        = (sync_clk[2:1] == 2'b10);
  assign unused_sync = sync_dat[2];
  assign fsm_state   = state;
  assign ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
  assign ps2_dat_oe  = dat_oe_r && ((state == RTS) || (state == SHIFT));

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_clk <= 3'b111;
      sync_dat <= 3'b111;
    end else begin
      sync_clk <= {sync_clk[1:0], ps2_clk_in};
      sync_dat <= {sync_dat[1:0], ps2_dat_in};
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          to_active;
  logic          to_hit;

  assign to_active = (state == RTS) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  // A falling edge restarts the watchdog, so it only fires on a stalled device clock.
  assign to_hit    = to_active && !fall && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (clr || !to_active) to_cnt <= '0;
    else if (fall)         to_cnt <= '0;
    else                   to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_n  = state;
    tx_ready = 1'b0;
    done     = 1'b0;
    ack_ok   = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) state_n = INHIBIT;
      end
      INHIBIT:   if (inh_cnt == INH_LAST) state_n = RTS;
      RTS:       state_n = SHIFT;
      SHIFT:     if (fall && edge_cnt == 4'd9) state_n = ACK;
      ACK:       if (fall) state_n = WAIT_IDLE;
      WAIT_IDLE: begin
        if (sync_clk[1] && sync_dat[1]) begin
          done    = 1'b1;
          ack_ok  = ack_r;
          err     = ~ack_r;
          state_n = IDLE;
        end
      end
      default:   state_n = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (to_hit && !done) begin
      state_n = IDLE;
      done    = 1'b1;
      ack_ok  = 1'b0;
      err     = 1'b1;
    end
`endif
    if (clr) begin
      done   = 1'b0;
      ack_ok = 1'b0;
      err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      data_r   <= '0;
      par_r    <= 1'b0;
      edge_cnt <= '0;
      inh_cnt  <= '0;
      dat_oe_r <= 1'b0;
      ack_r    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            data_r   <= tx_data;
            par_r    <= ~^tx_data;
            edge_cnt <= '0;
            inh_cnt  <= '0;
            ack_r    <= 1'b0;
            dat_oe_r <= 1'b0;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (state_n == RTS) dat_oe_r <= 1'b1;
        end
        SHIFT: begin
          // edge_cnt holds the number of edges already seen, so it indexes the next bit.
          if (fall && edge_cnt != 4'd11) begin
            edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt < 4'd8)       dat_oe_r <= ~data_r[edge_cnt[2:0]];
            else if (edge_cnt == 4'd8) dat_oe_r <= ~par_r;
            else                       dat_oe_r <= 1'b0;
          end
        end
        ACK: begin
          if (fall && edge_cnt != 4'd11) begin
            edge_cnt <= edge_cnt + 1'b1;
            ack_r    <= ~sync_dat[1];
          end
        end
        default: ;
      endcase
      if (state_n == IDLE) dat_oe_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND PS/2 lines, device model, frame and result scoreboards.
module tb_ps2_host_tx;
  localparam int INH = 5000;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO = 1000;
`else
  localparam int TO = 1000000;
`endif
  localparam int M_ACK = 0, M_NACK = 1, M_ABORT = 2, M_SILENT = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       tx_ready, done, ack_ok, err;
  logic [2:0] fsm_state;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clr(clr), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done), .ack_ok(ack_ok),
    .err(err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [10:0] frame_q[$];
  logic [1:0]  res_q[$];
  int          mode_q[$];
  int          done_cyc = -1;
  int          rts_cyc = -1;
  int          inh_run = 0;
  bit          abort_hit = 1'b0;
  logic [1:0]  mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Result monitor: every done pulse pops one expected {ack_ok, err}.
  always @(negedge clk) begin
    if (!clr) begin
      if (done) begin
        done_cyc = cyc;
        if (res_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          mon_e = res_q.pop_front();
          check("done_result", {ack_ok, err}, mon_e);
        end
      end else if (ack_ok || err) begin
        check("flag_without_done", {ack_ok, err}, 0);
      end
    end
  end

  // Inhibit monitor: length of clock-low-only phase before request-to-send.
  always @(negedge clk) begin
    if (clr) inh_run = 0;
    else if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
    else if (ps2_clk_oe && ps2_dat_oe) begin
      if (inh_run != 0) begin
        check("inhibit_len", inh_run, INH);
        rts_cyc = cyc;
      end
      inh_run = 0;
    end else inh_run = 0;
  end

  // Device model: clocks the frame in, samples each bit while its clock is low, optionally ACKs.
  initial begin : device
    int m, hp, lp;
    logic [10:0] f;
    forever begin
      wait (ps2_clk_oe == 1'b1);
      wait (ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1);
      m = (mode_q.size() == 0) ? M_ACK : mode_q.pop_front();
      if (m == M_SILENT) continue;
      hp = $urandom_range(10, 20);
      lp = $urandom_range(10, 20);
      f = '0;
      repeat (hp) @(negedge clk);
      f[0] = ps2_dat_in;
      for (int i = 1; i <= 11; i++) begin
        dev_clk_low = 1'b1;
        repeat (lp) @(negedge clk);
        if (i <= 10) f[i] = ps2_dat_in;
        dev_clk_low = 1'b0;
        if (m == M_ABORT && i == 5) break;
        if (i == 10 && m == M_ACK) begin
          repeat (hp / 2) @(negedge clk);
          dev_dat_low = 1'b1;
          repeat (hp - hp / 2) @(negedge clk);
        end else begin
          repeat (hp) @(negedge clk);
        end
      end
      dev_dat_low = 1'b0;
      if (m == M_ABORT) abort_hit = 1'b1;
      else if (frame_q.size() == 0) check("unexpected_frame", 1, 0);
      else check("frame_bits", f, frame_q.pop_front());
    end
  end

  task automatic push_exp(input logic [7:0] b, input int m);
    if (m == M_ACK || m == M_NACK) frame_q.push_back(model_frame(b));
    if (m != M_ABORT) res_q.push_back((m == M_ACK) ? 2'b10 : 2'b01);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!tx_ready && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) check(name, 0, 1);
  endtask

  task automatic send(input logic [7:0] b, input int m);
    mode_q.push_back(m);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    wait_ready("accept_timeout");
    @(posedge clk);
    push_exp(b, m);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((res_q.size() != 0 || !tx_ready) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) check("done_timeout", 0, 1);
    check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
  endtask

  initial begin : main
    int n;
    logic [7:0] rb;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_flags", {done, ack_ok, err}, 0);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    send(8'hED, M_ACK);  wait_done();
    send(8'h07, M_ACK);  wait_done();
    send(8'h00, M_NACK); wait_done();

    // Reset in the middle of a frame, then a clean retry.
    send(8'hF4, M_ABORT);
    n = 0;
    while (!abort_hit && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check("abort_point_timeout", 0, 1);
    clr = 1'b1;
    @(negedge clk);
    check("abort_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("abort_tx_ready", tx_ready, 1);
    clr = 1'b0;
    abort_hit = 1'b0;
    repeat (100) @(negedge clk);
    send(8'hF4, M_ACK); wait_done();

    // Held request: second byte must wait for the first done, then go next IDLE cycle.
    mode_q.push_back(M_ACK);
    mode_q.push_back(M_ACK);
    @(negedge clk);
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    wait_ready("held_accept1_timeout");
    @(posedge clk);
    push_exp(8'hED, M_ACK);
    @(negedge clk);
    tx_data = 8'hFF;
    wait_ready("held_accept2_timeout");
    check("held_accept_cycle", cyc, done_cyc + 1);
    @(posedge clk);
    push_exp(8'hFF, M_ACK);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_done();

    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      send(rb, int'($urandom_range(0, 1)));
      wait_done();
    end

`ifdef PS2_TX_TIMEOUT_EN
    send(8'hA5, M_SILENT);
    wait_done();
    check("timeout_latency", done_cyc + 1 - rts_cyc, TO);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
